bitwise_seq: RTL

Multi-byte bitwise-operation sequencer for the ez8 processor. On a single start strobe it walks two source operand strings and one destination string in data memory, one byte at a time. For each byte it reads operand A, reads operand B, drives the `bitwise` unit with a latched operation configuration, and writes the result back. It sits between the instruction decoder (command side) and the data-memory port (shared with the core via the existing memory mux), and reports an aggregate zero flag for the status register.

---
 rtl/ez8_pkg.sv | 21 ++
 rtl/bitwise.sv | 34 +++
 rtl/bitwise_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ez8_pkg.sv
// Shared ez8 definitions: sequencer state encoding and bitwise-unit select codes.
package ez8_pkg;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        WR   = 2'd3
    } state_e;

    // op_sel: bit 1 set selects XOR regardless of bit 0
    localparam logic [1:0] OP_AND    = 2'b00;
    localparam logic [1:0] OP_OR     = 2'b01;
    localparam logic [1:0] OP_XOR    = 2'b10;

    // b_sel: bit 1 set forces zero regardless of bit 0
    localparam logic [1:0] BSEL_PASS = 2'b00;
    localparam logic [1:0] BSEL_ONES = 2'b01;
    localparam logic [1:0] BSEL_ZERO = 2'b10;
endpackage

// File: rtl/bitwise.sv
// ez8 bitwise unit: operand swap/force muxing followed by AND/OR/XOR.
module bitwise
    import ez8_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_a_sel,
    input  logic [1:0]        i_b_sel,
    input  logic [1:0]        i_op_sel,
    output logic [DATA_W-1:0] o_res_c
);
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    always_comb begin
        w_a = i_a_sel ? i_b : i_a;

        if (i_b_sel[1]) begin
            w_b = '0;
        end else if (i_b_sel == BSEL_ONES) begin
            w_b = '1;
        end else begin
            w_b = i_b;
        end

        if (i_op_sel[1]) begin
            o_res_c = w_a ^ w_b;
        end else if (i_op_sel == OP_OR) begin
            o_res_c = w_a | w_b;
        end else begin
            o_res_c = w_a & w_b;
        end
    end
endmodule

// File: rtl/bitwise_seq.sv
// Multi-byte bitwise sequencer: per byte reads A, reads B, writes the bitwise result.
module bitwise_seq
    import ez8_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        cfg_op_sel,
    input  logic              cfg_a_sel,
    input  logic [1:0]        cfg_b_sel,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_accept;
    logic [1:0]          r_op_sel;
    logic                r_a_sel;
    logic [1:0]          r_b_sel;
    logic [ADDR_W-1:0]   r_a_ptr;
    logic [ADDR_W-1:0]   r_b_ptr;
    logic [ADDR_W-1:0]   r_d_ptr;
    logic [LEN_W-1:0]    r_rem;
    logic [DATA_W-1:0]   r_a_reg;
    logic                r_zero;
    logic                r_done;
    logic [DATA_W-1:0]   w_res;

    bitwise u_bitwise (
        .i_a      (r_a_reg),
        .i_b      (mem_rdata),
        .i_a_sel  (r_a_sel),
        .i_b_sel  (r_b_sel),
        .i_op_sel (r_op_sel),
        .o_res_c  (w_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; len=0 is accepted but never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (len != '0) begin
                        w_state_nxt = RD_A;
                    end
                end
            end
            RD_A:    w_state_nxt = RD_B;
            RD_B:    w_state_nxt = WR;
            WR:      w_state_nxt = (r_rem == LEN_W'(1)) ? IDLE : RD_A;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory port decoded from state so reset silences it immediately.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            RD_A: begin
                mem_rd   = 1'b1;
                mem_addr = r_a_ptr;
            end
            RD_B: begin
                mem_rd   = 1'b1;
                mem_addr = r_b_ptr;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_addr  = r_d_ptr;
                mem_wdata = w_res;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign zero = r_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_sel <= '0;
            r_a_sel  <= 1'b0;
            r_b_sel  <= '0;
            r_a_ptr  <= '0;
            r_b_ptr  <= '0;
            r_d_ptr  <= '0;
            r_rem    <= '0;
            r_a_reg  <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_accept && (len == '0)) ||
                      ((r_state == WR) && (r_rem == LEN_W'(1)));
            if (w_accept) begin
                r_op_sel <= cfg_op_sel;
                r_a_sel  <= cfg_a_sel;
                r_b_sel  <= cfg_b_sel;
                r_a_ptr  <= src_a;
                r_b_ptr  <= src_b;
                r_d_ptr  <= dst;
                r_rem    <= len;
                r_zero   <= 1'b1;
            end
            if (r_state == RD_B) begin
                r_a_reg <= mem_rdata;
            end
            if (r_state == WR) begin
                r_zero  <= r_zero & (w_res == '0);
                r_a_ptr <= r_a_ptr + ADDR_W'(1);
                r_b_ptr <= r_b_ptr + ADDR_W'(1);
                r_d_ptr <= r_d_ptr + ADDR_W'(1);
                r_rem   <= r_rem - LEN_W'(1);
            end
        end
    end
endmodule
